// File: rtl/serial_addsub_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// Optional signed-overflow flag is present when SERIAL_ADDSUB_OVF_EN is defined.
interface serial_addsub_ctrl_if #(
    parameter int W = 8
);
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic         ovf;
`endif

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout
`ifdef SERIAL_ADDSUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout
`ifdef SERIAL_ADDSUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor controller: one full-adder cell iterated over W
// cycles, LSB first, with the carry held in a flip-flop between cycles.
// Define SERIAL_ADDSUB_OVF_EN to add the signed-overflow output (bus.ovf).
//
// state | meaning
// IDLE  | waiting for start; result/cout hold last values
// RUN   | one result bit produced per cycle, busy=1
// FIN   | done pulse, cout valid; a start here is accepted as in IDLE
module serial_addsub_ctrl #(
    parameter int W  = 8,
    parameter int CW = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_addsub_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, b_q, result_q;
    logic [CW-1:0]  cnt_q;
    logic           carry_q;
    logic           cout_q;
    logic           load;
    logic           last;
    logic           fa_s;
    logic           fa_co;

    // Single full-adder cell fed from the shift-register LSBs and the carry FF.
    assign fa_s  = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_co = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    assign last  = (cnt_q == CW'(W - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode; a start in FIN reloads operands just like IDLE.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) state_d = FIN;
            end
            FIN: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB stage differs from the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          ovf_q <= 1'b0;
        else if (state_q == RUN && last)     ovf_q <= carry_q ^ fa_co;
    end

    assign bus.ovf = ovf_q;
`endif

    // Operand shift registers, carry FF, iteration counter and result shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
        end else if (load) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_q      <= a_q >> 1;
            b_q      <= b_q >> 1;
            result_q <= {fa_s, result_q[W-1:1]};
            carry_q  <= fa_co;
            cnt_q    <= cnt_q + 1'b1;
            if (last) cout_q <= fa_co;
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == FIN);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl (W=8); expected values hand-computed.
module tb_serial_addsub_ctrl;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;

    serial_addsub_ctrl_if #(.W(W)) bus_if ();

    serial_addsub_ctrl #(.W(W), .CW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands and a one-cycle start; returns 1 cycle after the start edge.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        bus_if.a     = av;
        bus_if.b     = bv;
        bus_if.sub   = sv;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        bus_if.a     = ~av;
        bus_if.b     = ~bv;
        bus_if.sub   = ~sv;
    endtask

    // Waits (bounded) for done; done must arrive exactly W edges after the start edge.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus_if.done !== 1'b1 && n < 3 * W) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, W);
    endtask

    task automatic op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic sv, input logic [W-1:0] er, input logic ec);
        launch(av, bv, sv);
        chk({tag, "_busy"}, bus_if.busy, 1);
        wait_done(tag);
        chk({tag, "_result"}, bus_if.result, er);
        chk({tag, "_cout"}, bus_if.cout, ec);
        chk({tag, "_busy_fin"}, bus_if.busy, 0);
        tick();
        chk({tag, "_done_1cyc"}, bus_if.done, 0);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.sub   = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        #12;
        chk("rst_busy",   bus_if.busy,   0);
        chk("rst_done",   bus_if.done,   0);
        chk("rst_result", bus_if.result, 0);
        chk("rst_cout",   bus_if.cout,   0);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("rst_ovf",    bus_if.ovf,    0);
`endif
        rst_n = 1'b1;
        tick();

        op("add_3c_05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0);
        op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_result", bus_if.result, 8'h00);
        end
        chk("hold_cout", bus_if.cout, 1);
        op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
        op("sub_07_05", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1);

        // Start while busy is ignored; then a start in the FIN cycle is accepted.
        launch(8'h10, 8'h20, 1'b0);
        tick();
        tick();
        bus_if.a     = 8'hAA;
        bus_if.b     = 8'h55;
        bus_if.sub   = 1'b1;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        chk("ignore_busy", bus_if.busy, 1);
        // Three RUN edges already consumed after the start edge.
        begin
            int n;
            n = 3;
            while (bus_if.done !== 1'b1 && n < 3 * W) begin
                tick();
                n++;
            end
            chk("ignore_latency", n, W);
        end
        chk("ignore_result", bus_if.result, 8'h30);
        chk("ignore_cout",   bus_if.cout,   0);
        launch(8'h01, 8'h01, 1'b0);
        chk("fin_start_busy", bus_if.busy, 1);
        chk("fin_start_done", bus_if.done, 0);
        wait_done("fin_start");
        chk("fin_start_result", bus_if.result, 8'h02);
        tick();

        // Reset mid-RUN aborts with no done pulse.
        launch(8'h10, 8'h20, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy",   bus_if.busy,   0);
        chk("abort_done",   bus_if.done,   0);
        chk("abort_result", bus_if.result, 0);
        chk("abort_cout",   bus_if.cout,   0);
        tick();
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 2 * W; i++) begin
                tick();
                if (bus_if.done === 1'b1) seen++;
            end
            chk("abort_no_done", seen, 0);
        end
        op("add_0a_0b", 8'h0A, 8'h0B, 1'b0, 8'h15, 1'b0);

`ifdef SERIAL_ADDSUB_OVF_EN
        op("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        chk("ovf_7f_01_flag", bus_if.ovf, 1);
        op("ovf_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1);
        chk("ovf_80_01_flag", bus_if.ovf, 1);
        op("ovf_10_10", 8'h10, 8'h10, 1'b0, 8'h20, 1'b0);
        chk("ovf_10_10_flag", bus_if.ovf, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
